mc_digit_rx: RTL and testbench

- Receiving end of the MC14433 multiplexed BCD readout: samples Q[3:0] under the digit strobes DS1..DS4.
- Assembles one 3½-digit frame and decodes the DS1 status nibble.
- Commits the frame atomically to output registers only after the sequence DS1→DS2→DS3→DS4 completes cleanly.
- Sits between the converter core (or an external MC14433) and the display/host logic.

---
 rtl/mc14433_pkg.sv | 63 ++++++
 rtl/mc_strobe_qual.sv | 56 +++++
 rtl/mc_digit_rx.sv | 189 ++++++++++++++++++
 tb/tb_mc_digit_rx.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc14433_pkg.sv
// Shared types and constants for the MC14433 multiplexed BCD readout receiver.
package mc14433_pkg;

  typedef enum logic [3:0] {
    ST_HUNT,
    ST_CAP1,
    ST_REL1,
    ST_CAP2,
    ST_REL2,
    ST_CAP3,
    ST_REL3,
    ST_CAP4,
    ST_REL4
  } rx_state_e;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_ONE   = 2'd1,
    CLS_MULTI = 2'd2
  } ds_cls_e;

  localparam logic [1:0] DS1 = 2'd0;
  localparam logic [1:0] DS2 = 2'd1;
  localparam logic [1:0] DS3 = 2'd2;
  localparam logic [1:0] DS4 = 2'd3;

  localparam int Q_HALFB = 3;
  localparam int Q_POL   = 2;
  localparam int Q_RNG   = 0;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Settling state for a strobe index.
  function automatic rx_state_e cap_state(input logic [1:0] idx);
    case (idx)
      DS1:     return ST_CAP1;
      DS2:     return ST_CAP2;
      DS3:     return ST_CAP3;
      default: return ST_CAP4;
    endcase
  endfunction

  // Post-capture state for a strobe index.
  function automatic rx_state_e rel_state(input logic [1:0] idx);
    case (idx)
      DS1:     return ST_REL1;
      DS2:     return ST_REL2;
      DS3:     return ST_REL3;
      default: return ST_REL4;
    endcase
  endfunction

  // Strobe index a CAPn/RELn state is working on.
  function automatic logic [1:0] slot_of(input rx_state_e st);
    case (st)
      ST_CAP1, ST_REL1: return DS1;
      ST_CAP2, ST_REL2: return DS2;
      ST_CAP3, ST_REL3: return DS3;
      default:          return DS4;
    endcase
  endfunction

endpackage

// File: rtl/mc_strobe_qual.sv
// Digit-strobe qualifier: classifies DS as none/one-hot/multi and counts how
// long the same one-hot strobe has been stable.
module mc_strobe_qual
  import mc14433_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rb,
  input  logic [3:0] ds,
  output logic [1:0] cls,
  output logic [1:0] idx,
  output logic       fresh,
  output logic       cap
);

  localparam logic [4:0] SETTLE_CNT = 5'(SETTLE);

  logic [3:0] ds_q, ds_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] ones;
  logic       one;

  // Classify the strobe word and advance the stability counter.
  always_comb begin
    ones = {2'b00, ds[0]} + {2'b00, ds[1]} + {2'b00, ds[2]} + {2'b00, ds[3]};
    one  = (ones == 3'd1);
    cls  = (ones == 3'd0) ? CLS_NONE : (one ? CLS_ONE : CLS_MULTI);
    case (ds)
      4'b0010: idx = DS2;
      4'b0100: idx = DS3;
      4'b1000: idx = DS4;
      default: idx = DS1;
    endcase
    ds_d = ds;
    // Saturating well above any legal SETTLE keeps cap a single pulse.
    if (!one)                cnt_d = 5'd0;
    else if (ds != ds_q)     cnt_d = 5'd1;
    else if (cnt_q != 5'h1F) cnt_d = cnt_q + 5'd1;
    else                     cnt_d = cnt_q;
    fresh = one && (cnt_d == 5'd1);
    cap   = one && (cnt_d == SETTLE_CNT);
  end

  // Previous strobe word and stability count.
  always_ff @(posedge clk) begin
    if (!rb) begin
      ds_q  <= 4'd0;
      cnt_q <= 5'd0;
    end else begin
      ds_q  <= ds_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_digit_rx.sv
// MC14433 readout receiver: assembles one 3 1/2 digit frame from the
// multiplexed BCD bus and commits it atomically after a clean DS1..DS4 pass.
//
// state | meaning
// HUNT  | idle, waiting for a fresh DS1
// CAPn  | strobe n seen, waiting for it to settle before sampling Q
// RELn  | slot n captured, waiting for strobe n+1 (REL4: for release, then commit)
module mc_digit_rx
  import mc14433_pkg::*;
#(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic       CP,
  input  logic       RB,
  input  logic [3:0] DS,
  input  logic [3:0] Q,
  output logic       HALF,
  output logic       POL,
  output logic       OVR,
  output logic       UNR,
  output logic [3:0] D2,
  output logic [3:0] D3,
  output logic [3:0] D4,
  output logic       FVLD,
  output logic       FERR,
  output logic [7:0] ERRCNT
);

  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  logic [1:0] cls, idx, cur, cap_slot;
  logic       fresh, cap, cap_go, abort, commit;

  rx_state_e       state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [3:0][3:0] shd_q, shd_d;
  logic [3:0]      flg_q, flg_d;
  logic [3:0]      d2_q, d2_d, d3_q, d3_d, d4_q, d4_d;
  logic            fvld_q, fvld_d, ferr_q, ferr_d;
  logic [7:0]      errcnt_q, errcnt_d;

  mc_strobe_qual #(.SETTLE(SETTLE)) u_qual (
    .clk  (CP),
    .rb   (RB),
    .ds   (DS),
    .cls  (cls),
    .idx  (idx),
    .fresh(fresh),
    .cap  (cap)
  );

  // Frame sequencing, capture, timeout, commit and abort handling.
  always_comb begin
    state_d  = state_q;
    tmr_d    = (state_q != ST_HUNT && tmr_q != '0) ? tmr_q - 1'b1 : tmr_q;
    shd_d    = shd_q;
    flg_d    = flg_q;
    d2_d     = d2_q;
    d3_d     = d3_q;
    d4_d     = d4_q;
    fvld_d   = 1'b0;
    ferr_d   = 1'b0;
    errcnt_d = errcnt_q;
    cap_go   = 1'b0;
    cap_slot = DS1;
    abort    = 1'b0;
    commit   = 1'b0;
    cur      = slot_of(state_q);

    case (state_q)
      ST_HUNT: begin
        // Only a newly appearing DS1 starts a frame; a strobe left over
        // from an aborted frame must drop first.
        if (cls == CLS_ONE && idx == DS1 && fresh) begin
          tmr_d = TMR_LOAD;
          if (cap) begin
            cap_go   = 1'b1;
            cap_slot = DS1;
          end else begin
            state_d = ST_CAP1;
          end
        end
      end
      ST_CAP1, ST_CAP2, ST_CAP3, ST_CAP4: begin
        if (cls == CLS_ONE && idx == cur) begin
          if (cap) begin
            cap_go   = 1'b1;
            cap_slot = cur;
          end
        end else begin
          abort = 1'b1;
        end
      end
      ST_REL1, ST_REL2, ST_REL3: begin
        if (cls == CLS_MULTI) begin
          abort = 1'b1;
        end else if (cls == CLS_ONE && idx != cur) begin
          if (idx == cur + 2'd1) begin
            if (cap) begin
              cap_go   = 1'b1;
              cap_slot = idx;
            end else begin
              state_d = cap_state(idx);
            end
          end else begin
            abort = 1'b1;
          end
        end
      end
      ST_REL4: begin
        if (cls == CLS_NONE) commit = 1'b1;
        else if (!(cls == CLS_ONE && idx == DS4)) abort = 1'b1;
      end
      default: state_d = ST_HUNT;
    endcase

    if (cap_go) begin
      if (cap_slot != DS1 && Q > BCD_MAX) begin
        abort = 1'b1;
      end else begin
        shd_d[cap_slot] = Q;
        tmr_d           = TMR_LOAD;
        state_d         = rel_state(cap_slot);
      end
    end

    // Progress (a capture or the commit) in the expiry cycle still wins.
    if (state_q != ST_HUNT && !cap_go && !commit && tmr_q == '0) abort = 1'b1;

    if (abort) begin
      state_d = ST_HUNT;
      shd_d   = '0;
      ferr_d  = 1'b1;
      if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
    end else if (commit) begin
      state_d = ST_HUNT;
      flg_d   = {~shd_q[DS1][Q_HALFB],
                 shd_q[DS1][Q_POL],
                 shd_q[DS1][Q_RNG] & ~shd_q[DS1][Q_HALFB],
                 shd_q[DS1][Q_RNG] & shd_q[DS1][Q_HALFB]};
      d2_d    = shd_q[DS2];
      d3_d    = shd_q[DS3];
      d4_d    = shd_q[DS4];
      shd_d   = '0;
      fvld_d  = 1'b1;
    end
  end

  // State, timer, shadow and output registers.
  always_ff @(posedge CP) begin
    if (!RB) begin
      state_q  <= ST_HUNT;
      tmr_q    <= '0;
      shd_q    <= '0;
      flg_q    <= 4'd0;
      d2_q     <= 4'd0;
      d3_q     <= 4'd0;
      d4_q     <= 4'd0;
      fvld_q   <= 1'b0;
      ferr_q   <= 1'b0;
      errcnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      shd_q    <= shd_d;
      flg_q    <= flg_d;
      d2_q     <= d2_d;
      d3_q     <= d3_d;
      d4_q     <= d4_d;
      fvld_q   <= fvld_d;
      ferr_q   <= ferr_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign HALF   = flg_q[3];
  assign POL    = flg_q[2];
  assign OVR    = flg_q[1];
  assign UNR    = flg_q[0];
  assign D2     = d2_q;
  assign D3     = d3_q;
  assign D4     = d4_q;
  assign FVLD   = fvld_q;
  assign FERR   = ferr_q;
  assign ERRCNT = errcnt_q;

endmodule

// File: tb/tb_mc_digit_rx.sv
// Bench for mc_digit_rx: expected frames are queued as they are sent and
// checked when FVLD appears; abort scenarios check FERR/ERRCNT directly.
module tb_mc_digit_rx;

  typedef struct packed {
    logic       half;
    logic       pol;
    logic       ovr;
    logic       unr;
    logic [3:0] d2;
    logic [3:0] d3;
    logic [3:0] d4;
  } frame_t;

  logic       CP = 1'b0;
  logic       RB;
  logic [3:0] DS;
  logic [3:0] Q;
  logic       HALF, POL, OVR, UNR, FVLD, FERR;
  logic [3:0] D2, D3, D4;
  logic [7:0] ERRCNT;

  int     total = 0;
  int     bad   = 0;
  int     fvld_cnt = 0;
  int     ferr_cnt = 0;
  int     exp_err  = 0;
  frame_t sb[$];
  frame_t last_exp = '0;
  frame_t exp_f;
  frame_t got_f;

  mc_digit_rx #(.SETTLE(2), .TIMEOUT(20), .TW(10)) dut (
    .CP(CP), .RB(RB), .DS(DS), .Q(Q),
    .HALF(HALF), .POL(POL), .OVR(OVR), .UNR(UNR),
    .D2(D2), .D3(D3), .D4(D4),
    .FVLD(FVLD), .FERR(FERR), .ERRCNT(ERRCNT)
  );

  always #5 CP = ~CP;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every committed frame must match the oldest queued expectation.
  always @(negedge CP) begin
    if (FVLD || FERR) begin
      total++;
      if (FVLD && FERR) begin
        bad++;
        $display("FAIL fvld_ferr_exclusive: FVLD=%b FERR=%b, want not both", FVLD, FERR);
      end
    end
    if (FERR) ferr_cnt++;
    if (FVLD) begin
      fvld_cnt++;
      total++;
      got_f = {HALF, POL, OVR, UNR, D2, D3, D4};
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_frame: got %h, no frame expected", got_f);
      end else begin
        exp_f = sb.pop_front();
        last_exp = exp_f;
        if (got_f !== exp_f) begin
          bad++;
          $display("FAIL sb_frame: got %h want %h", got_f, exp_f);
        end
      end
    end
  end

  // Hold strobe k with data qv for hi cycles, then release for gap cycles.
  task automatic strobe(input int k, input logic [3:0] qv, input int hi, input int gap);
    DS = 4'b0001 << k;
    Q  = qv;
    repeat (hi) @(posedge CP);
    #1 DS = 4'd0;
    Q = 4'd0;
    repeat (gap) @(posedge CP);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] q1, q2, q3, q4);
    strobe(0, q1, 4, 2);
    strobe(1, q2, 4, 2);
    strobe(2, q3, 4, 2);
    strobe(3, q4, 4, 2);
  endtask

  task automatic wait_frames(input int n, input string name);
    for (int i = 0; i < 40 && fvld_cnt < n; i++) begin
      @(posedge CP);
      #1;
    end
    total++;
    if (fvld_cnt < n || sb.size() != 0) begin
      bad++;
      $display("FAIL %s_commit: frames=%0d pending=%0d, want frames=%0d pending=0",
               name, fvld_cnt, sb.size(), n);
    end
  endtask

  task automatic check_abort(input string name, input int ferr_before);
    repeat (3) @(posedge CP);
    #1;
    total++;
    if (ferr_cnt - ferr_before !== 1) begin
      bad++;
      $display("FAIL %s_ferr: pulses=%0d want 1", name, ferr_cnt - ferr_before);
    end
    total++;
    if (ERRCNT !== 8'(exp_err)) begin
      bad++;
      $display("FAIL %s_errcnt: got %0d want %0d", name, ERRCNT, exp_err);
    end
    total++;
    if ({HALF, POL, OVR, UNR, D2, D3, D4} !== last_exp) begin
      bad++;
      $display("FAIL %s_hold: got %h want %h", name, {HALF, POL, OVR, UNR, D2, D3, D4}, last_exp);
    end
  endtask

  task automatic test_reset();
    RB = 1'b0;
    DS = 4'd0;
    Q  = 4'd0;
    repeat (3) @(posedge CP);
    #1;
    total++;
    if ({HALF, POL, OVR, UNR, D2, D3, D4, FVLD, FERR, ERRCNT} !== 26'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {HALF, POL, OVR, UNR, D2, D3, D4, FVLD, FERR, ERRCNT});
    end
    RB = 1'b1;
    repeat (2) @(posedge CP);
    #1;
  endtask

  task automatic test_clean();
    int n;
    n = fvld_cnt;
    sb.push_back('{half: 1'b1, pol: 1'b1, ovr: 1'b0, unr: 1'b0, d2: 4'd1, d3: 4'd9, d4: 4'd5});
    strobe(0, 4'b0100, 4, 2);
    strobe(1, 4'd1, 4, 2);
    strobe(2, 4'd9, 4, 2);
    strobe(3, 4'd5, 4, 0);
    @(negedge CP);
    total++;
    if (FVLD !== 1'b0) begin
      bad++;
      $display("FAIL clean_fvld_early: FVLD=%b want 0", FVLD);
    end
    @(negedge CP);
    total++;
    if (FVLD !== 1'b1) begin
      bad++;
      $display("FAIL clean_fvld_timing: FVLD=%b want 1", FVLD);
    end
    @(negedge CP);
    total++;
    if (FVLD !== 1'b0) begin
      bad++;
      $display("FAIL clean_fvld_width: FVLD=%b want 0", FVLD);
    end
    wait_frames(n + 1, "clean");
  endtask

  task automatic test_out_of_order();
    int f;
    f = ferr_cnt;
    strobe(0, 4'b0100, 4, 2);
    strobe(1, 4'd3, 4, 2);
    strobe(3, 4'd7, 4, 2);
    exp_err++;
    check_abort("ooo", f);
    f = fvld_cnt;
    sb.push_back('{half: 1'b1, pol: 1'b0, ovr: 1'b0, unr: 1'b0, d2: 4'd8, d3: 4'd0, d4: 4'd3});
    send_frame(4'b0000, 4'd8, 4'd0, 4'd3);
    wait_frames(f + 1, "ooo_recover");
  endtask

  task automatic test_glitch();
    int f;
    f = ferr_cnt;
    strobe(0, 4'b0100, 4, 2);
    strobe(1, 4'd2, 4, 2);
    strobe(2, 4'd2, 1, 4);
    exp_err++;
    check_abort("glitch", f);
  endtask

  task automatic test_bad_bcd();
    int f;
    f = ferr_cnt;
    strobe(0, 4'b0100, 4, 2);
    strobe(1, 4'd2, 4, 2);
    strobe(2, 4'hC, 4, 2);
    strobe(3, 4'd1, 4, 2);
    exp_err++;
    check_abort("bad_bcd", f);
  endtask

  task automatic test_range();
    int n;
    n = fvld_cnt;
    sb.push_back('{half: 1'b1, pol: 1'b0, ovr: 1'b1, unr: 1'b0, d2: 4'd0, d3: 4'd0, d4: 4'd0});
    send_frame(4'b0001, 4'd0, 4'd0, 4'd0);
    wait_frames(n + 1, "range_ovr");
    total++;
    if ({OVR, HALF} !== 2'b11) begin
      bad++;
      $display("FAIL range_ovr_flags: OVR,HALF=%b want 11", {OVR, HALF});
    end
    sb.push_back('{half: 1'b0, pol: 1'b0, ovr: 1'b0, unr: 1'b1, d2: 4'd2, d3: 4'd3, d4: 4'd4});
    send_frame(4'b1001, 4'd2, 4'd3, 4'd4);
    wait_frames(n + 2, "range_unr");
    total++;
    if ({UNR, HALF} !== 2'b10) begin
      bad++;
      $display("FAIL range_unr_flags: UNR,HALF=%b want 10", {UNR, HALF});
    end
  endtask

  task automatic test_timeout();
    int f;
    int hit;
    f   = ferr_cnt;
    hit = 0;
    strobe(0, 4'b0100, 4, 2);
    DS = 4'b0010;
    Q  = 4'd6;
    @(posedge CP);
    @(posedge CP);
    #1 DS = 4'd0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge CP);
      #1;
      if (FERR && hit == 0) hit = k;
    end
    exp_err++;
    total++;
    if (hit !== 20) begin
      bad++;
      $display("FAIL timeout_cycle: FERR after %0d edges want 20", hit);
    end
    check_abort("timeout", f);
  endtask

  task automatic test_reset_midframe();
    int n;
    n = fvld_cnt;
    strobe(0, 4'b0100, 4, 2);
    strobe(1, 4'd4, 4, 2);
    DS = 4'b0100;
    Q  = 4'd4;
    @(posedge CP);
    #1 RB = 1'b0;
    @(posedge CP);
    #1 RB = 1'b1;
    total++;
    if ({HALF, POL, OVR, UNR, D2, D3, D4, FVLD, FERR, ERRCNT} !== 26'd0) begin
      bad++;
      $display("FAIL midreset_outputs: got %h want 0", {HALF, POL, OVR, UNR, D2, D3, D4, FVLD, FERR, ERRCNT});
    end
    exp_err  = 0;
    last_exp = '0;
    repeat (3) @(posedge CP);
    #1 DS = 4'd0;
    repeat (2) @(posedge CP);
    #1;
    strobe(3, 4'd4, 4, 6);
    total++;
    if (fvld_cnt !== n || ERRCNT !== 8'd0) begin
      bad++;
      $display("FAIL midreset_no_frame: frames=%0d errcnt=%0d want frames=%0d errcnt=0", fvld_cnt, ERRCNT, n);
    end
  endtask

  task automatic test_saturation();
    int f;
    f = ferr_cnt;
    for (int i = 0; i < 300; i++) begin
      DS = 4'b0001;
      @(posedge CP);
      #1 DS = 4'd0;
      @(posedge CP);
      #1;
      if (i == 254) begin
        total++;
        if (ERRCNT !== 8'd255) begin
          bad++;
          $display("FAIL sat_reach: got %0d want 255", ERRCNT);
        end
      end
    end
    @(posedge CP);
    #1;
    total++;
    if (ERRCNT !== 8'd255) begin
      bad++;
      $display("FAIL sat_hold: got %0d want 255", ERRCNT);
    end
    total++;
    if (ferr_cnt - f !== 300) begin
      bad++;
      $display("FAIL sat_ferr_pulses: got %0d want 300", ferr_cnt - f);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = fvld_cnt;
    sb.push_back('{half: 1'b0, pol: 1'b1, ovr: 1'b0, unr: 1'b0, d2: 4'd7, d3: 4'd6, d4: 4'd9});
    send_frame(4'b1100, 4'd7, 4'd6, 4'd9);
    sb.push_back('{half: 1'b1, pol: 1'b1, ovr: 1'b0, unr: 1'b0, d2: 4'd0, d3: 4'd1, d4: 4'd2});
    send_frame(4'b0110, 4'd0, 4'd1, 4'd2);
    wait_frames(n + 2, "b2b");
  endtask

  initial begin
    test_reset();
    test_clean();
    test_out_of_order();
    test_glitch();
    test_bad_bcd();
    test_range();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    test_saturation();
    repeat (4) @(posedge CP);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
